note_glyph_renderer: RTL and testbench
======================================

// Module: note_glyph_renderer
// PURPOSE
//  Pixel-pipeline stage directly upstream of the note glyph ROM (8x8 glyphs, codes 0x00-0x1F, addr = {code[4:0], row[2:0]}).
//  Holds a COLS x ROWS grid of glyph codes, written by the sequencer/NIOS side.
//  Maps each VGA DrawX/DrawY to a grid cell and drives the ROM address from that cell's code.
//  Consumes the ROM row byte and emits a per-pixel foreground/highlight flag for the colour mapper.
// PARAMETERS
//  X0     64  left pixel of grid region
//  Y0     96  top pixel of grid region
//  COLS   64  grid columns (cells 8 px wide); region width COLS*8
//  ROWS    8  grid rows (cells 8 px tall); region height ROWS*8
// PORTS
//  Clk          in   1   system clock (pixel-enable domain); one clock
//  Reset        in   1   synchronous, active-high reset
//  DrawX        in   10  current pixel x
//  DrawY        in   10  current pixel y
//  de_in        in   1   display enable for DrawX/DrawY
//  wr_en        in   1   grid write strobe
//  wr_col       in   6   grid column to write
//  wr_row       in   3   grid row to write
//  wr_code      in   5   glyph code to write
//  clear_start  in   1   pulse: zero entire grid
//  clear_busy   out  1   high while clear sweep runs
//  hl_en        in   1   enable column highlight
//  hl_col       in   6   highlighted (now-playing) column
//  rom_addr     out  8   to glyph ROM addr
//  rom_data     in   8   from glyph ROM (combinational, same cycle); bit 7 = leftmost pixel
//  pixel_on     out  1   glyph foreground at this pixel
//  pixel_hl     out  1   pixel lies in highlighted column (inside region)
//  de_out       out  1   de_in delayed to match pixel_on/pixel_hl
// BEHAVIOUR
//  Reset: pixel_on, pixel_hl, de_out, clear_busy = 0.
//  Reset also zeroes rom_addr and all pipeline registers and puts the FSM in IDLE.
//  Grid RAM contents are NOT reset.
//  Pipeline, fixed latency 3 (DrawX/DrawY/de_in at edge N -> pixel_on/pixel_hl/de_out valid after edge N+3):
//   S1  reg region_s1 = de_in & X0<=DrawX<X0+COLS*8 & Y0<=DrawY<Y0+ROWS*8.
//       Offsets dx = DrawX-X0, dy = DrawY-Y0.
//       Register col_s1 = dx[8:3], row_s1 = dy[5:3], gy_s1 = dy[2:0], gx_s1 = dx[2:0].
//   S2  synchronous RAM read at {row_s1,col_s1} -> code_s2.
//       Forward gy/gx/region/de/hl_match (hl_en & col_s1==hl_col).
//       rom_addr = region_s2 ? {code_s2, gy_s2} : 8'h00 (combinational from S2 regs).
//   S3  pixel_on <= region_s2 & rom_data[7-gx_s2]; pixel_hl <= region_s2 & hl_match_s2; de_out <= de_s2.
//  Outside region, or de_in=0: pixel_on = pixel_hl = 0 after latency. Code 0x00 renders blank.
//  Pipeline runs every cycle; there is no stall.
//  Write port, IDLE only:
//   wr_en with wr_col<COLS and wr_row<ROWS writes wr_code at that edge.
//   Out-of-range write is dropped.
//  Same-cycle read and write of one cell: the read returns the OLD code (read-before-write).
//  Clear FSM:
//   IDLE -> CLEAR on clear_start; counter = 0, clear_busy = 1 from the next cycle.
//   CLEAR writes 0 to cell[counter] each cycle, counter++.
//   At counter == COLS*ROWS-1: write, then -> IDLE, clear_busy = 0 the next cycle.
//   Sweep occupies exactly COLS*ROWS cycles.
//   In CLEAR, wr_en and clear_start are ignored (no restart); the render pipeline keeps reading.
//   Reset mid-clear: -> IDLE, clear_busy = 0, partially cleared grid kept as-is.
//  Width rules: offsets computed in 11-bit signed space so DrawX<X0 is never treated as in-region. hl_col>=COLS never matches.
// TESTING
//  1. Reset, write (col 0, row 0) = 0x01; scan DrawX=64..71, DrawY=97.
//     -> rom_addr=0x09 in S2; pixel_on pattern 00011000 three cycles later.
//  2. DrawX=63 and DrawX=576, DrawY=100 with de_in=1 -> pixel_on=0, pixel_hl=0, rom_addr=0x00.
//  3. hl_en=1, hl_col=5, code 0x02 at (5,2); DrawX=104..111, DrawY=113
//     -> pixel_hl=1 all 8 px; pixel_on 10000001.
//  4. clear_start after filling grid -> clear_busy high for exactly 512 cycles.
//     wr_en during sweep is dropped; all cells then read 0.
//  5. Reset asserted 100 cycles into a clear
//     -> clear_busy=0 next cycle; cells 0..99 = 0, later cells retain their values.
//  6. Write 0x03 to the cell being rendered in the same cycle
//     -> that pixel uses the old code; the following pixel uses 0x03.

Source files
------------

// File: rtl/note_glyph_renderer_if.sv
// Pixel, grid-write, highlight and glyph-ROM signals between the renderer and its neighbours.
// master drives pixel/write/highlight inputs and the ROM byte; slave is the renderer.
interface note_glyph_renderer_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       de_in;
    logic       wr_en;
    logic [5:0] wr_col;
    logic [2:0] wr_row;
    logic [4:0] wr_code;
    logic       clear_start;
    logic       clear_busy;
    logic       hl_en;
    logic [5:0] hl_col;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       pixel_on;
    logic       pixel_hl;
    logic       de_out;

    modport master (
        output DrawX, DrawY, de_in, wr_en, wr_col, wr_row, wr_code,
               clear_start, hl_en, hl_col, rom_data,
        input  clear_busy, rom_addr, pixel_on, pixel_hl, de_out
    );

    modport slave (
        input  DrawX, DrawY, de_in, wr_en, wr_col, wr_row, wr_code,
               clear_start, hl_en, hl_col, rom_data,
        output clear_busy, rom_addr, pixel_on, pixel_hl, de_out
    );
endinterface

// File: rtl/note_glyph_renderer.sv
// Maps DrawX/DrawY onto a grid of glyph codes, addresses the glyph ROM and emits per-pixel fg/highlight.
// Fixed 3-cycle latency, never stalls; grid writes are taken only while no clear sweep is running.
module note_glyph_renderer #(
    parameter int X0   = 64,
    parameter int Y0   = 96,
    parameter int COLS = 64,
    parameter int ROWS = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    note_glyph_renderer_if.slave  bus
);
    localparam int CELLS = COLS * ROWS;
    localparam logic signed [10:0] X0S = 11'(X0);
    localparam logic signed [10:0] Y0S = 11'(Y0);
    localparam logic signed [10:0] XW  = 11'(COLS * 8);
    localparam logic signed [10:0] YH  = 11'(ROWS * 8);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;

    logic [4:0] mem [512];
    logic       mem_we;
    logic [8:0] mem_waddr;
    logic [4:0] mem_wdat;

    // Signed offsets keep pixels left of / above the region from wrapping into it.
    logic signed [10:0] dx, dy;
    logic               region_d;

    logic       region_s1_q, de_s1_q;
    logic [5:0] col_s1_q;
    logic [2:0] row_s1_q, gy_s1_q, gx_s1_q;

    logic       region_s2_q, de_s2_q, hl_s2_q;
    logic [2:0] gy_s2_q, gx_s2_q;
    logic [4:0] code_s2_q;
    logic       hl_match;

    logic       on_q, hl_q, de_q;

    assign dx = $signed({1'b0, bus.DrawX}) - X0S;
    assign dy = $signed({1'b0, bus.DrawY}) - Y0S;
    assign region_d = bus.de_in && (dx >= 11'sd0) && (dx < XW)
                                && (dy >= 11'sd0) && (dy < YH);

    assign hl_match = bus.hl_en && (int'(bus.hl_col) < COLS) && (col_s1_q == bus.hl_col);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = {bus.wr_row, bus.wr_col};
        mem_wdat  = bus.wr_code;
        case (state_q)
            IDLE: begin
                if (bus.wr_en && (int'(bus.wr_col) < COLS) && (int'(bus.wr_row) < ROWS)) begin
                    mem_we = 1'b1;
                end
                if (bus.clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdat  = '0;
                cnt_d     = cnt_q + 9'd1;
                if (cnt_q == 9'(CELLS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grid contents survive reset; a reset edge must not land a write either.
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            region_s1_q <= 1'b0;
            de_s1_q     <= 1'b0;
            col_s1_q    <= '0;
            row_s1_q    <= '0;
            gy_s1_q     <= '0;
            gx_s1_q     <= '0;
            region_s2_q <= 1'b0;
            de_s2_q     <= 1'b0;
            hl_s2_q     <= 1'b0;
            gy_s2_q     <= '0;
            gx_s2_q     <= '0;
            code_s2_q   <= '0;
            on_q        <= 1'b0;
            hl_q        <= 1'b0;
            de_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            region_s1_q <= region_d;
            de_s1_q     <= bus.de_in;
            col_s1_q    <= dx[8:3];
            row_s1_q    <= dy[5:3];
            gy_s1_q     <= dy[2:0];
            gx_s1_q     <= dx[2:0];
            region_s2_q <= region_s1_q;
            de_s2_q     <= de_s1_q;
            hl_s2_q     <= hl_match;
            gy_s2_q     <= gy_s1_q;
            gx_s2_q     <= gx_s1_q;
            code_s2_q   <= mem[{row_s1_q, col_s1_q}];
            on_q        <= region_s2_q & bus.rom_data[3'd7 - gx_s2_q];
            hl_q        <= region_s2_q & hl_s2_q;
            de_q        <= de_s2_q;
        end
    end

    assign bus.rom_addr   = region_s2_q ? {code_s2_q, gy_s2_q} : 8'h00;
    assign bus.pixel_on   = on_q;
    assign bus.pixel_hl   = hl_q;
    assign bus.de_out     = de_q;
    assign bus.clear_busy = (state_q == CLEAR);
endmodule

// File: tb/tb_note_glyph_renderer.sv
// Directed and randomized checks of note_glyph_renderer against a pixel-arithmetic reference model.
module tb_note_glyph_renderer;
    localparam int X0 = 64, Y0 = 96, COLS = 64, ROWS = 8, CELLS = 512;

    typedef struct {
        bit         chk;
        bit         de;
        bit         on;
        bit         hl;
        logic [7:0] ra;
    } pexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   gm [CELLS];
    bit   hl_en_m = 1'b0;
    int   hl_col_m = 0;
    bit   sweeping = 1'b0;
    pexp_t q[$];
    logic [7:0] on_hist = 8'h00;
    logic [7:0] hl_hist = 8'h00;

    always #5 clk = ~clk;

    note_glyph_renderer_if bus();

    note_glyph_renderer #(.X0(X0), .Y0(Y0), .COLS(COLS), .ROWS(ROWS)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        if (a == 8'h09) return 8'h18;
        if (a == 8'h11) return 8'h81;
        if (a[7:3] == 5'd0) return 8'h00;
        return 8'(a * 8'd29) ^ 8'h5A;
    endfunction

    assign bus.rom_data = rom_f(bus.rom_addr);

    function automatic pexp_t model(input int x, input int y, input bit de);
        pexp_t      e;
        int         cx, cy, code;
        logic [7:0] r;
        e.chk = 1'b1;
        e.de  = de;
        e.on  = 1'b0;
        e.hl  = 1'b0;
        e.ra  = 8'h00;
        if (de && x >= X0 && x < X0 + COLS * 8 && y >= Y0 && y < Y0 + ROWS * 8) begin
            cx   = x - X0;
            cy   = y - Y0;
            code = gm[(cy / 8) * COLS + cx / 8];
            e.ra = 8'(code * 8 + cy % 8);
            r    = rom_f(e.ra);
            e.on = r[7 - cx % 8];
            e.hl = hl_en_m && (hl_col_m == cx / 8);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs due now, then drive this cycle's pixel and optional grid write.
    task automatic tick(input int x, input int y, input bit de, input bit c,
                        input bit we = 1'b0, input int wcol = 0, input int wrow = 0,
                        input int wcode = 0);
        pexp_t e;
        @(posedge clk);
        #1;
        on_hist = {on_hist[6:0], bus.pixel_on};
        hl_hist = {hl_hist[6:0], bus.pixel_hl};
        if (q.size() >= 2 && q[q.size() - 2].chk)
            chk("rom_addr", 32'(bus.rom_addr), 32'(q[q.size() - 2].ra));
        if (q.size() >= 3 && q[q.size() - 3].chk) begin
            chk("pixel_on", 32'(bus.pixel_on), 32'(q[q.size() - 3].on));
            chk("pixel_hl", 32'(bus.pixel_hl), 32'(q[q.size() - 3].hl));
            chk("de_out",   32'(bus.de_out),   32'(q[q.size() - 3].de));
        end
        bus.wr_en   = we;
        bus.wr_col  = 6'(wcol);
        bus.wr_row  = 3'(wrow);
        bus.wr_code = 5'(wcode);
        if (we && !sweeping) gm[wrow * COLS + wcol] = wcode;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.de_in = de;
        e = model(x, y, de);
        e.chk = c;
        q.push_back(e);
        if (q.size() > 3) void'(q.pop_front());
    endtask

    task automatic flush();
        repeat (3) tick(0, 0, 1'b0, 1'b0);
    endtask

    task automatic fill(input int lo);
        for (int i = 0; i < CELLS; i++)
            tick(0, 0, 1'b0, 1'b0, 1'b1, i % COLS, i / COLS, int'($urandom_range(31, lo)));
    endtask

    task automatic scan_cells();
        for (int i = 0; i < CELLS; i++)
            tick(X0 + (i % COLS) * 8 + (i % 8), Y0 + (i / COLS) * 8 + (i % 7) + 1, 1'b1, 1'b1);
        flush();
    endtask

    initial begin
        int n;
        int px, py;
        bus.DrawX = 10'd64; bus.DrawY = 10'd97; bus.de_in = 1'b1;
        bus.wr_en = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_code = '0;
        bus.clear_start = 1'b0; bus.hl_en = 1'b0; bus.hl_col = '0;
        for (int i = 0; i < CELLS; i++) gm[i] = 0;

        // Reset holds every output low even with an in-region pixel presented.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel_on",   32'(bus.pixel_on),   32'd0);
        chk("rst_pixel_hl",   32'(bus.pixel_hl),   32'd0);
        chk("rst_de_out",     32'(bus.de_out),     32'd0);
        chk("rst_clear_busy", 32'(bus.clear_busy), 32'd0);
        chk("rst_rom_addr",   32'(bus.rom_addr),   32'd0);
        rst = 1'b0;
        bus.de_in = 1'b0;

        // Code 0x01 at cell (0,0), glyph row 1.
        tick(0, 0, 1'b0, 1'b0, 1'b1, 0, 0, 1);
        for (int i = 0; i < 8; i++) tick(64 + i, 97, 1'b1, 1'b1);
        flush();
        chk("t1_pattern", 32'(on_hist), 32'h18);

        // Just outside the region horizontally and vertically.
        tick(63, 100, 1'b1, 1'b1);
        tick(576, 100, 1'b1, 1'b1);
        tick(100, 95, 1'b1, 1'b1);
        tick(100, 160, 1'b1, 1'b1);
        tick(0, 0, 1'b1, 1'b1);
        flush();

        // Highlighted column 5 with code 0x02 at (5,2).
        hl_en_m = 1'b1; hl_col_m = 5;
        bus.hl_en = 1'b1; bus.hl_col = 6'd5;
        tick(0, 0, 1'b0, 1'b0, 1'b1, 5, 2, 2);
        for (int i = 0; i < 8; i++) tick(104 + i, 113, 1'b1, 1'b1);
        flush();
        chk("t3_on_pattern", 32'(on_hist), 32'h81);
        chk("t3_hl_pattern", 32'(hl_hist), 32'hFF);

        // Random grid, random highlight, random pixels with interleaved writes.
        fill(0);
        hl_col_m = int'($urandom_range(63, 0));
        bus.hl_col = 6'(hl_col_m);
        flush();
        for (int i = 0; i < 400; i++) begin
            px = int'($urandom_range(620, 40));
            py = int'($urandom_range(168, 88));
            if ($urandom_range(3, 0) == 0)
                tick(px, py, $urandom_range(3, 0) != 0, 1'b1, 1'b1,
                     int'($urandom_range(63, 0)), int'($urandom_range(7, 0)),
                     int'($urandom_range(31, 0)));
            else
                tick(px, py, $urandom_range(3, 0) != 0, 1'b1);
        end
        flush();
        hl_en_m = 1'b0;
        bus.hl_en = 1'b0;

        // Write lands on the cell in the same cycle it is read: old code first, new code next pixel.
        tick(0, 0, 1'b0, 1'b0, 1'b1, 10, 3, 31);
        tick(0, 0, 1'b0, 1'b0);
        tick(X0 + 80, Y0 + 26, 1'b1, 1'b1);
        tick(X0 + 81, Y0 + 26, 1'b1, 1'b1, 1'b1, 10, 3, 3);
        tick(X0 + 82, Y0 + 26, 1'b1, 1'b1);
        flush();

        // Full clear sweep, with a write and a restart attempt during it.
        tick(0, 0, 1'b0, 1'b0);
        bus.clear_start = 1'b1;
        tick(0, 0, 1'b0, 1'b0);
        bus.clear_start = 1'b0;
        sweeping = 1'b1;
        n = 0;
        for (int i = 0; i < 700; i++) begin
            if (!bus.clear_busy) break;
            n++;
            bus.clear_start = (i == 200);
            if (i == 50) tick(0, 0, 1'b0, 1'b0, 1'b1, 0, 0, 7);
            else         tick(0, 0, 1'b0, 1'b0);
        end
        bus.clear_start = 1'b0;
        sweeping = 1'b0;
        chk("clear_busy_cycles", 32'(n), 32'd512);
        for (int i = 0; i < CELLS; i++) gm[i] = 0;
        scan_cells();

        // Reset 100 cycles into a sweep keeps the partially cleared grid.
        fill(1);
        tick(0, 0, 1'b0, 1'b0);
        bus.clear_start = 1'b1;
        tick(0, 0, 1'b0, 1'b0);
        bus.clear_start = 1'b0;
        sweeping = 1'b1;
        repeat (100) tick(0, 0, 1'b0, 1'b0);
        chk("busy_before_reset", 32'(bus.clear_busy), 32'd1);
        rst = 1'b1;
        tick(0, 0, 1'b0, 1'b0);
        chk("busy_after_reset", 32'(bus.clear_busy), 32'd0);
        rst = 1'b0;
        sweeping = 1'b0;
        q.delete();
        for (int i = 0; i < 100; i++) gm[i] = 0;
        scan_cells();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
